key_matrix_arbiter: RTL and testbench
=====================================

# key_matrix_arbiter

Sequences all accesses to the shared single-port key-matrix RAM that backs the PET keyboard (10 rows × 8 columns). Two requesters share the RAM. The Pi writes row images at addresses 0xE800..0xE809. PIA1 selects a row via port A and reads its columns via port B. The block arbitrates and queues Pi writes, keeps the currently selected row's column byte pre-fetched for the PIA1 read path, and clears the matrix after reset.

## Interface
- ROWS, 10, number of matrix rows; RAM rows 0..ROWS-1 are valid
- FIFO_DEPTH, 4, Pi write queue depth (power of two)
- CLEAR_VALUE, 8'hFF, value written to every row after reset ("no key pressed")
- BASE_ADDR, 16'hE800, Pi address of row 0
---
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- pi_addr  in  16  Pi write address
- pi_data  in  8  Pi write data (row image)
- pi_write  in  1  Pi write strobe; rising edge = one request
- pi_ready  out  1  queue not full
- pi_overflow  out  1  sticky; a decoded write arrived while queue full
- row_sel  in  4  PIA1 port A row select (low nibble)
- ram_addr  out  4  RAM row address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, valid the cycle after a read address is presented
- kbd_cols  out  8  column byte for row_sel, consumed by the PIA1 port B read mux
- cols_valid  out  1  kbd_cols reflects current row_sel and all completed writes
- busy  out  1  post-reset clear in progress

## Operation
- Decode: a rising edge of pi_write with BASE_ADDR ≤ pi_addr < BASE_ADDR+ROWS enqueues {row = pi_addr−BASE_ADDR, data}. Other addresses are ignored. pi_write held high counts once.
- Queue full at enqueue: request dropped, pi_overflow set until reset. Enqueue and dequeue in the same cycle are legal when full.
- row_sel ≥ ROWS: kbd_cols = 8'hFF, cols_valid = 1, and no RAM read is issued.
- FSM states:
  - CLEAR: rows 0..ROWS-1 written with CLEAR_VALUE, one per cycle. Then goes to IDLE with refresh pending.
  - IDLE: selects the next operation.
  - WRITE: one cycle; ram_we = 1 with the FIFO head; entry popped.
  - READ: ram_addr = registered row_sel, ram_we = 0.
  - CAPTURE: kbd_cols ← ram_rdata; cols_valid = 1 unless row_sel changed meanwhile.
- IDLE priority: pending refresh > non-empty queue > stay idle.
- Refresh pending is set by:
  - a change of registered row_sel (cols_valid cleared the next cycle);
  - exit from CLEAR;
  - a WRITE to the currently selected row (cols_valid cleared the same edge).
- A row_sel change during READ/CAPTURE discards that capture, leaves cols_valid = 0, and re-arms refresh.
- Writes to non-selected rows never affect kbd_cols or cols_valid.
- Pi writes arriving during CLEAR are queued and applied after CLEAR.

## Timing
- Reset values: ram_addr 0, ram_we 0, ram_wdata 0, kbd_cols 8'hFF, cols_valid 0, busy 1, pi_ready 1, pi_overflow 0. The FIFO is emptied.
- Reset asserted mid-operation: the outputs above hold from the next edge, state goes to CLEAR, and any in-flight write or capture is abandoned.
- CLEAR takes ROWS cycles. busy falls the cycle after row ROWS-1 is written. The first refresh completes 3 cycles later.
- row_sel is registered once. A change sampled at edge N gives cols_valid = 0 from N+1 and cols_valid = 1 by N+4 if idle. Worst case is N+5 when a WRITE occupies cycle N+1.
- A Pi strobe edge sampled at edge N gives FIFO occupancy from N+1 and the earliest ram_we in cycle N+1.
  - If the row equals row_sel: updated kbd_cols by N+4.
- A constantly changing row_sel may starve the queue. This is accepted: real PIA scans hold each row ≥ 4 µs.
- pi_ready deasserts the cycle after the FIFO_DEPTH-th entry is queued.

## Test plan
- Reset then row_sel = 0: busy high for 10 cycles. ram writes of 0xFF to rows 0..9 in order. kbd_cols = 0xFF with cols_valid = 1 within 3 cycles of busy falling.
- For row r = 0..9, Pi writes 1<<(r mod 8) to 0xE800+r, then row_sel = r: kbd_cols = 1<<(r mod 8), cols_valid = 1 within 5 cycles.
- With row_sel = 3, Pi writes 0x5A to 0xE803: cols_valid drops, then kbd_cols = 0x5A within 4 cycles. A following write to 0xE804 leaves kbd_cols = 0x5A and cols_valid high.
- Five writes strobed back-to-back while a refresh is pending: pi_ready drops after the fourth, pi_overflow = 1, the fifth write is not applied, and rows 0..3 read back correctly.
- pi_addr = 0xE80A or 0xE7FF strobed: no enqueue and no ram_we. row_sel = 12 gives kbd_cols = 0xFF, cols_valid = 1.
- Reset asserted during a WRITE with 3 entries queued: queue emptied, all rows read back 0xFF after CLEAR, pi_overflow = 0.

Source files
------------

// File: rtl/key_matrix_arbiter.sv
// Arbiter for the shared single-port PET key-matrix RAM: clears the matrix after reset,
// queues Pi row writes and keeps the selected row's column byte prefetched for PIA1.
module key_matrix_arbiter #(
  parameter int          ROWS        = 10,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [7:0]  CLEAR_VALUE = 8'hFF,
  parameter logic [15:0] BASE_ADDR   = 16'hE800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] pi_addr,
  input  logic [7:0]  pi_data,
  input  logic        pi_write,
  output logic        pi_ready,
  output logic        pi_overflow,
  input  logic [3:0]  row_sel,
  output logic [3:0]  ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  kbd_cols,
  output logic        cols_valid,
  output logic        busy
);

  localparam int                PTR_W    = $clog2(FIFO_DEPTH);
  localparam int                CNT_W    = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]       ROWS16   = 16'(ROWS);
  localparam logic [4:0]        ROWS5    = 5'(ROWS);
  localparam logic [3:0]        LAST_ROW = 4'(ROWS - 1);

  typedef enum logic [2:0] {
    ST_CLEAR,
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CAPTURE
  } state_t;

  state_t             state, state_next;
  logic [3:0]         clr_cnt;
  logic               pi_write_q;
  logic [3:0]         row_sel_q;
  logic               refresh_pending;

  logic [3:0]         fifo_row  [FIFO_DEPTH];
  logic [7:0]         fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;

  logic [15:0]        addr_off;
  logic               decoded, full, push, pop, overflow_set;
  logic               sel_change, sel_in_range;
  logic               start_read, skip_read;
  logic [3:0]         head_row;
  logic [7:0]         head_data;

  // Pi side has no handshake: each pi_write rising edge is one request, and pi_ready
  // only reports that the queue has room; a request seen while full is dropped.
  assign addr_off     = pi_addr - BASE_ADDR;
  assign decoded      = pi_write && !pi_write_q && (pi_addr >= BASE_ADDR) && (addr_off < ROWS16);
  assign full         = (count == DEPTH_C);
  assign push         = decoded && (!full || pop);
  assign overflow_set = decoded && full && !pop;
  assign pi_ready     = !full;
  assign head_row     = fifo_row[rd_ptr];
  assign head_data    = fifo_data[rd_ptr];
  assign sel_change   = (row_sel != row_sel_q);
  assign sel_in_range = ({1'b0, row_sel_q} < ROWS5);

  // A pending refresh always wins over queued writes so the PIA path never reads stale data.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    start_read = 1'b0;
    skip_read  = 1'b0;
    case (state)
      ST_CLEAR: if (clr_cnt == LAST_ROW) state_next = ST_IDLE;
      ST_IDLE, ST_WRITE: begin
        state_next = ST_IDLE;
        if (refresh_pending) begin
          if (sel_in_range) begin
            state_next = ST_READ;
            start_read = 1'b1;
          end else begin
            skip_read = 1'b1;
          end
        end else if (count != '0) begin
          state_next = ST_WRITE;
          pop        = 1'b1;
        end
      end
      ST_READ:    state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_IDLE;
      default:    state_next = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_CLEAR;
      clr_cnt         <= '0;
      pi_write_q      <= 1'b0;
      row_sel_q       <= '0;
      refresh_pending <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      pi_overflow     <= 1'b0;
      ram_addr        <= '0;
      ram_we          <= 1'b0;
      ram_wdata       <= '0;
      kbd_cols        <= 8'hFF;
      cols_valid      <= 1'b0;
      busy            <= 1'b1;
    end else begin
      state      <= state_next;
      pi_write_q <= pi_write;
      row_sel_q  <= row_sel;
      ram_we     <= 1'b0;

      if (push) begin
        fifo_row[wr_ptr]  <= addr_off[3:0];
        fifo_data[wr_ptr] <= pi_data;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (overflow_set) pi_overflow <= 1'b1;

      if (state == ST_CLEAR) begin
        ram_we    <= 1'b1;
        ram_addr  <= clr_cnt;
        ram_wdata <= CLEAR_VALUE;
        if (clr_cnt == LAST_ROW) begin
          busy            <= 1'b0;
          refresh_pending <= 1'b1;
        end else begin
          clr_cnt <= clr_cnt + 4'd1;
        end
      end

      if (start_read) begin
        ram_addr        <= row_sel_q;
        refresh_pending <= 1'b0;
      end
      // Rows beyond the matrix read as "no key pressed" without touching the RAM.
      if (skip_read) begin
        kbd_cols        <= 8'hFF;
        cols_valid      <= 1'b1;
        refresh_pending <= 1'b0;
      end
      if (pop) begin
        ram_we    <= 1'b1;
        ram_addr  <= head_row;
        ram_wdata <= head_data;
        if (head_row == row_sel_q) begin
          cols_valid      <= 1'b0;
          refresh_pending <= 1'b1;
        end
      end

      // A capture is only trusted if the selection did not move since the read was issued.
      if (state == ST_CAPTURE && !refresh_pending && !sel_change) begin
        kbd_cols   <= ram_rdata;
        cols_valid <= 1'b1;
      end

      if (sel_change) begin
        cols_valid      <= 1'b0;
        refresh_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_key_matrix_arbiter.sv
// Directed bench for key_matrix_arbiter with a behavioural single-port RAM model.
module tb_key_matrix_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] pi_addr = 16'h0000;
  logic [7:0]  pi_data = 8'h00;
  logic        pi_write = 1'b0;
  logic        pi_ready;
  logic        pi_overflow;
  logic [3:0]  row_sel = 4'd0;
  logic [3:0]  ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  kbd_cols;
  logic        cols_valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram_model [16];
  logic [7:0] ovf_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  always #5 clk = ~clk;

  // Rows outside the matrix hold a non-FF pattern so a stray read would show up.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) ram_model[i] <= 8'hA5;
    end else begin
      if (ram_we) ram_model[ram_addr] <= ram_wdata;
      ram_rdata <= ram_model[ram_addr];
    end
  end

  key_matrix_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .pi_addr     (pi_addr),
    .pi_data     (pi_data),
    .pi_write    (pi_write),
    .pi_ready    (pi_ready),
    .pi_overflow (pi_overflow),
    .row_sel     (row_sel),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .kbd_cols    (kbd_cols),
    .cols_valid  (cols_valid),
    .busy        (busy)
  );

  task automatic pi_wr(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    pi_addr  = a;
    pi_data  = d;
    pi_write = 1'b1;
    @(posedge clk); #1;
    pi_write = 1'b0;
  endtask

  task automatic set_row(input logic [3:0] r);
    @(posedge clk); #1;
    row_sel = r;
  endtask

  // lat = index of the first cycle after the sampling edge with cols_valid high, -1 on timeout
  task automatic wait_valid(input int max_cycles, output int lat);
    lat = -1;
    @(posedge clk);
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk);
      if (cols_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic read_row(input logic [3:0] r, input logic [7:0] exp, input string name);
    int lat;
    set_row(r);
    wait_valid(12, lat);
    checks++;
    if (lat < 0 || kbd_cols !== exp) begin
      errors++;
      $display("FAIL %s row %0d: kbd_cols=%h latency=%0d, expected %h", name, r, kbd_cols, lat, exp);
    end
  endtask

  task automatic test_reset();
    logic [11:0] exp_q[$];
    logic [11:0] seen_q[$];
    logic [11:0] exp_w;
    int busy_cycles, first_low, first_valid;
    busy_cycles = 0;
    first_low   = -1;
    first_valid = -1;
    row_sel  = 4'd0;
    pi_write = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({ram_addr, ram_we, ram_wdata, kbd_cols, cols_valid, busy, pi_ready, pi_overflow} !==
        {4'h0, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_values: addr=%h we=%b wdata=%h cols=%h valid=%b busy=%b ready=%b ovf=%b",
               ram_addr, ram_we, ram_wdata, kbd_cols, cols_valid, busy, pi_ready, pi_overflow);
    end
    for (int i = 0; i < 10; i++) exp_q.push_back({4'(i), 8'hFF});
    for (int i = 0; i < 20; i++) begin
      if (i > 0) @(negedge clk);
      if (busy) busy_cycles++;
      else if (first_low < 0) first_low = i;
      if (cols_valid && first_valid < 0) first_valid = i;
      if (ram_we) seen_q.push_back({ram_addr, ram_wdata});
    end
    checks++;
    if (busy_cycles != 10) begin
      errors++;
      $display("FAIL clear_busy_cycles: got %0d, expected 10", busy_cycles);
    end
    checks++;
    if (seen_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL clear_write_count: got %0d, expected %0d", seen_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && seen_q.size() > 0) begin
      exp_w = exp_q.pop_front();
      checks++;
      if (seen_q[0] !== exp_w) begin
        errors++;
        $display("FAIL clear_write_order: got row %h data %h, expected row %h data %h",
                 seen_q[0][11:8], seen_q[0][7:0], exp_w[11:8], exp_w[7:0]);
      end
      void'(seen_q.pop_front());
    end
    checks++;
    if (first_low < 0 || first_valid <= first_low || first_valid - first_low > 3 || kbd_cols !== 8'hFF) begin
      errors++;
      $display("FAIL first_refresh: busy_low_at=%0d valid_at=%0d cols=%h, expected valid within 3 and cols ff",
               first_low, first_valid, kbd_cols);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k <= 10; k++) begin
      @(posedge clk); #1;
      row_sel  = (k % 2 == 0) ? 4'd1 : 4'd0;
      pi_write = (k % 2 == 0) && (k < 10);
      if (k < 10) begin
        pi_addr = 16'hE800 + 16'(k / 2);
        pi_data = ovf_data[k / 2];
      end
      @(negedge clk);
      if (k == 5) begin
        checks++;
        if (pi_ready !== 1'b1) begin
          errors++;
          $display("FAIL ready_after_third: pi_ready=%b, expected 1", pi_ready);
        end
      end
      if (k == 7) begin
        checks++;
        if (pi_ready !== 1'b0) begin
          errors++;
          $display("FAIL ready_after_fourth: pi_ready=%b, expected 0", pi_ready);
        end
      end
      if (k == 9) begin
        checks++;
        if (pi_overflow !== 1'b1) begin
          errors++;
          $display("FAIL overflow_flag: pi_overflow=%b, expected 1", pi_overflow);
        end
      end
    end
    repeat (25) @(posedge clk);
    @(negedge clk);
    checks++;
    if (pi_ready !== 1'b1 || pi_overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_drain: ready=%b ovf=%b, expected ready 1 ovf 1", pi_ready, pi_overflow);
    end
    for (int r = 0; r < 4; r++) read_row(4'(r), ovf_data[r], "overflow_readback");
    read_row(4'd4, 8'hFF, "overflow_dropped");
  endtask

  task automatic test_row_writes();
    int lat;
    logic [7:0] v;
    for (int r = 0; r < 10; r++) begin
      v = 8'(1 << (r % 8));
      pi_wr(16'hE800 + 16'(r), v);
      set_row(4'(r));
      wait_valid(6, lat);
      checks++;
      if (lat < 0 || lat > 4 || kbd_cols !== v) begin
        errors++;
        $display("FAIL row_write row %0d: kbd_cols=%h latency=%0d, expected %h within 4", r, kbd_cols, lat, v);
      end
    end
  endtask

  task automatic test_selected_write();
    int lat, drop_at, valid_at, bad;
    read_row(4'd3, 8'h08, "select_row3");
    @(posedge clk); #1;
    pi_addr  = 16'hE803;
    pi_data  = 8'h5A;
    pi_write = 1'b1;
    drop_at  = -1;
    valid_at = -1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1 pi_write = 1'b0;
      @(negedge clk);
      if (!cols_valid && drop_at < 0) drop_at = i;
      if (cols_valid && drop_at >= 0 && valid_at < 0) valid_at = i;
    end
    checks++;
    if (drop_at < 0 || valid_at < 0 || valid_at > 4 || kbd_cols !== 8'h5A) begin
      errors++;
      $display("FAIL selected_write: drop_at=%0d valid_at=%0d cols=%h, expected drop then 5a by 4",
               drop_at, valid_at, kbd_cols);
    end
    bad = 0;
    pi_wr(16'hE804, 8'h77);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cols_valid !== 1'b1 || kbd_cols !== 8'h5A) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL other_row_write: %0d disturbed cycles, expected 0", bad);
    end
    checks++;
    if (ram_model[4] !== 8'h77) begin
      errors++;
      $display("FAIL other_row_stored: row4=%h, expected 77", ram_model[4]);
    end
  endtask

  task automatic test_bad_addr();
    int wr, lat, bad;
    wr = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      pi_write = (i == 0) || (i == 2);
      pi_addr  = (i < 2) ? 16'hE80A : 16'hE7FF;
      pi_data  = 8'h00;
      @(negedge clk);
      if (ram_we) wr++;
    end
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL bad_addr_writes: %0d ram writes, expected 0", wr);
    end
    set_row(4'd12);
    wait_valid(6, lat);
    checks++;
    if (lat < 0 || lat > 4 || kbd_cols !== 8'hFF) begin
      errors++;
      $display("FAIL row_out_of_range: cols=%h latency=%0d, expected ff within 4", kbd_cols, lat);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (cols_valid !== 1'b1 || kbd_cols !== 8'hFF || ram_addr === 4'd12) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL row_out_of_range_hold: %0d bad cycles, expected 0", bad);
    end
  endtask

  task automatic test_reset_mid_write();
    int found, low_at, wr;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      row_sel  = (k % 2 == 1) ? 4'd6 : 4'd5;
      pi_write = (k % 2 == 0);
      pi_addr  = 16'hE805 + 16'(k / 2);
      pi_data  = 8'h10 + 8'(k);
    end
    @(posedge clk); #1 pi_write = 1'b0;
    found = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ram_we) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (found == 0) begin
      errors++;
      $display("FAIL mid_write_start: no ram write within 20 cycles, expected one");
    end
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    low_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        low_at = i;
        break;
      end
    end
    checks++;
    if (low_at != 10) begin
      errors++;
      $display("FAIL mid_reset_clear: busy fell at %0d, expected 10", low_at);
    end
    wr = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ram_we) wr++;
    end
    checks++;
    if (wr != 0 || pi_overflow !== 1'b0 || pi_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_queue: writes=%0d ovf=%b ready=%b, expected 0 0 1", wr, pi_overflow, pi_ready);
    end
    for (int r = 0; r < 10; r++) read_row(4'(r), 8'hFF, "mid_reset_readback");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_row_writes();
    test_selected_write();
    test_bad_addr();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
